// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared constants and FSM state encoding for the I2C write master
package i2c_pkg;

    localparam int   BYTE_W     = 8;
    localparam int   MAX_BYTES  = 5;
    localparam int   ADDR_W     = 7;
    localparam logic I2C_WR_BIT = 1'b0;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_WAIT  = 3'd1;
    localparam state_t ST_START = 3'd2;
    localparam state_t ST_SHIFT = 3'd3;
    localparam state_t ST_ACK   = 3'd4;
    localparam state_t ST_STOP  = 3'd5;
    localparam state_t ST_DONE  = 3'd6;

    function automatic int frame_bytes(input int reg_w, input int data_w);
        return 1 + reg_w / BYTE_W + data_w / BYTE_W;
    endfunction

endpackage

// File: rtl/i2c_wr_master_if.sv
// rtl/i2c_wr_master_if.sv - request, phase and open-drain bus signals of the I2C write master
interface i2c_wr_master_if
    import i2c_pkg::*;
#(
    parameter int REG_W  = 8,
    parameter int DATA_W = 8
) ();

    logic              i_scl_ph;
    logic              i_sda_ph;
    logic              start;
    logic [ADDR_W-1:0] dev_addr;
    logic [REG_W-1:0]  reg_addr;
    logic [DATA_W-1:0] wr_data;
    logic              sda_i;
    logic              scl;
    logic              sda_oen;
    logic              busy;
    logic              done;
    logic              ack_err;

    modport master (
        input  i_scl_ph, i_sda_ph, start, dev_addr, reg_addr, wr_data, sda_i,
        output scl, sda_oen, busy, done, ack_err
    );

    modport slave (
        output i_scl_ph, i_sda_ph, start, dev_addr, reg_addr, wr_data, sda_i,
        input  scl, sda_oen, busy, done, ack_err
    );

endinterface

// File: rtl/i2c_phase_edge.sv
// rtl/i2c_phase_edge.sv - registers a divider phase level and emits 1-cycle rise/fall pulses
module i2c_phase_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic lvl_i,
    output logic lvl_o,
    output logic rise_o,
    output logic fall_o
);

    logic cur_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q  <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            cur_q  <= lvl_i;
            prev_q <= cur_q;
        end
    end

    assign lvl_o  = cur_q;
    assign rise_o = cur_q & ~prev_q;
    assign fall_o = ~cur_q & prev_q;

endmodule

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for an asynchronous level input
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/i2c_wr_master.sv
// rtl/i2c_wr_master.sv - I2C write-only master (START, addr+W, reg, data, STOP); I2C_NACK_ABORT_EN ends on NACK
module i2c_wr_master
    import i2c_pkg::*;
#(
    parameter int REG_W  = 8,
    parameter int DATA_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    i2c_wr_master_if.master bus
);

    localparam int NBYTES  = frame_bytes(REG_W, DATA_W);
    localparam int FRAME_W = BYTE_W + REG_W + DATA_W;
    localparam int SH_W    = MAX_BYTES * BYTE_W;

    logic scl_lvl;
    logic unused_scl_rise;
    logic unused_scl_fall;
    logic unused_sda_lvl;
    logic qh;
    logic ql;
    logic sda_sync;
    logic nack_stop;
    logic last_byte;

    state_t          state_q,    state_d;
    logic [SH_W-1:0] sh_q,       sh_d;
    logic [2:0]      bit_cnt_q,  bit_cnt_d;
    logic [2:0]      byte_cnt_q, byte_cnt_d;
    logic            scl_en_q,   scl_en_d;
    logic            sda_oen_q,  sda_oen_d;
    logic            busy_q,     busy_d;
    logic            done_q,     done_d;
    logic            ack_err_q,  ack_err_d;

    i2c_phase_edge u_scl_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .lvl_i  (bus.i_scl_ph),
        .lvl_o  (scl_lvl),
        .rise_o (unused_scl_rise),
        .fall_o (unused_scl_fall)
    );

    i2c_phase_edge u_sda_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .lvl_i  (bus.i_sda_ph),
        .lvl_o  (unused_sda_lvl),
        .rise_o (qh),
        .fall_o (ql)
    );

    sync_2ff #(.RST_VAL(1'b1)) u_sda_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (bus.sda_i),
        .q_o   (sda_sync)
    );

    // Within a transaction ack_err can only have been set by this transfer's NACK.
`ifdef I2C_NACK_ABORT_EN
    assign nack_stop = ack_err_q;
`else
    assign nack_stop = 1'b0;
`endif

    assign last_byte = (byte_cnt_q == 3'(NBYTES - 1));

    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        scl_en_d   = scl_en_q;
        sda_oen_d  = sda_oen_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ack_err_d  = ack_err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    // Frame is left-aligned so the MSB of the shifter is always the next bit.
                    sh_d       = SH_W'({bus.dev_addr, I2C_WR_BIT, bus.reg_addr, bus.wr_data})
                                 << (SH_W - FRAME_W);
                    bit_cnt_d  = 3'd0;
                    byte_cnt_d = 3'd0;
                    busy_d     = 1'b1;
                    ack_err_d  = 1'b0;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (qh) begin
                    sda_oen_d = 1'b0;
                    scl_en_d  = 1'b1;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (ql) begin
                    sda_oen_d = sh_q[SH_W-1];
                    sh_d      = {sh_q[SH_W-2:0], 1'b0};
                    bit_cnt_d = 3'd1;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (ql) begin
                    if (bit_cnt_q == 3'd0) begin
                        sda_oen_d = 1'b1;
                        state_d   = ST_ACK;
                    end else begin
                        sda_oen_d = sh_q[SH_W-1];
                        sh_d      = {sh_q[SH_W-2:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            ST_ACK: begin
                if (qh && sda_sync) begin
                    ack_err_d = 1'b1;
                end
                if (ql) begin
                    byte_cnt_d = byte_cnt_q + 3'd1;
                    if (last_byte || nack_stop) begin
                        sda_oen_d = 1'b0;
                        state_d   = ST_STOP;
                    end else begin
                        sda_oen_d = sh_q[SH_W-1];
                        sh_d      = {sh_q[SH_W-2:0], 1'b0};
                        bit_cnt_d = 3'd1;
                        state_d   = ST_SHIFT;
                    end
                end
            end
            ST_STOP: begin
                if (qh) begin
                    sda_oen_d = 1'b1;
                    scl_en_d  = 1'b0;
                    done_d    = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sh_q       <= '0;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= 3'd0;
            scl_en_q   <= 1'b0;
            sda_oen_q  <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ack_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            scl_en_q   <= scl_en_d;
            sda_oen_q  <= sda_oen_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ack_err_q  <= ack_err_d;
        end
    end

    assign bus.scl     = scl_en_q ? scl_lvl : 1'b1;
    assign bus.sda_oen = sda_oen_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.ack_err = ack_err_q;

endmodule

// File: tb/tb_i2c_wr_master.sv
// tb/tb_i2c_wr_master.sv - randomized scoreboard bench with bus monitor and slave model for i2c_wr_master
`timescale 1ns/1ps
module tb_i2c_wr_master;

    // Divider at one tenth of 950/240, keeping the quarter-period phase offset.
    localparam int PH_N   = 95;
    localparam int PH_DLY = 24;
    localparam int TMO    = 60 * PH_N;
`ifdef I2C_NACK_ABORT_EN
    localparam bit ABORT = 1'b1;
`else
    localparam bit ABORT = 1'b0;
`endif

    logic clk    = 1'b0;
    logic rst_n  = 1'b1;
    logic scl_ph = 1'b1;
    logic sda_ph = 1'b0;

    logic        start_r   [2];
    logic [6:0]  dev_r     [2];
    logic [15:0] reg_r     [2];
    logic [15:0] data_r    [2];
    logic        scl_w     [2];
    logic        oen_w     [2];
    logic        busy_w    [2];
    logic        done_w    [2];
    logic        err_w     [2];
    logic        slave_low [2];
    logic        sda_line  [2];

    logic [7:0] exp_byte_q  [2][$];
    int         exp_pulse_q [2][$];
    bit         exp_err_q   [2][$];

    int         bit_idx [2], byte_idx [2], pulses [2], done_cnt [2], bytes_seen [2];
    bit         in_frame [2], seen_rise [2], prev_scl [2], prev_sda [2], mon_en [2], cur_err [2];
    logic [7:0] shreg [2];
    logic [4:0] nack_mask [2];

    int n_checks = 0;
    int n_err    = 0;

    i2c_wr_master_if #(.REG_W(8),  .DATA_W(8))  if_a ();
    i2c_wr_master_if #(.REG_W(16), .DATA_W(16)) if_b ();

    i2c_wr_master #(.REG_W(8),  .DATA_W(8))  dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.master));
    i2c_wr_master #(.REG_W(16), .DATA_W(16)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.master));

    assign if_a.i_scl_ph = scl_ph;
    assign if_a.i_sda_ph = sda_ph;
    assign if_a.start    = start_r[0];
    assign if_a.dev_addr = dev_r[0];
    assign if_a.reg_addr = reg_r[0][7:0];
    assign if_a.wr_data  = data_r[0][7:0];
    assign if_a.sda_i    = sda_line[0];
    assign if_b.i_scl_ph = scl_ph;
    assign if_b.i_sda_ph = sda_ph;
    assign if_b.start    = start_r[1];
    assign if_b.dev_addr = dev_r[1];
    assign if_b.reg_addr = reg_r[1];
    assign if_b.wr_data  = data_r[1];
    assign if_b.sda_i    = sda_line[1];

    assign scl_w[0]  = if_a.scl;     assign scl_w[1]  = if_b.scl;
    assign oen_w[0]  = if_a.sda_oen; assign oen_w[1]  = if_b.sda_oen;
    assign busy_w[0] = if_a.busy;    assign busy_w[1] = if_b.busy;
    assign done_w[0] = if_a.done;    assign done_w[1] = if_b.done;
    assign err_w[0]  = if_a.ack_err; assign err_w[1]  = if_b.ack_err;
    assign sda_line[0] = oen_w[0] & ~slave_low[0];
    assign sda_line[1] = oen_w[1] & ~slave_low[1];

    always #5 clk = ~clk;

    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            cnt    = (cnt + 1) % PH_N;
            scl_ph = (cnt < (PH_N + 1) / 2);
            sda_ph = (((cnt + PH_N - PH_DLY) % PH_N) < (PH_N + 1) / 2);
        end
    end

    task automatic chk(input string name, input int d, input int act, input int exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h at %0t", name, d, act, exp_v, $time);
        end
    endtask

    // Reference model: byte list, pulse count and NACK outcome from the operands alone.
    task automatic exp_push(input int d, input logic [6:0] dev, input logic [15:0] ra,
                            input logic [15:0] wd, input logic [4:0] mask);
        logic [7:0] b [$];
        int         np;
        bit         e;
        b.push_back({dev, 1'b0});
        if (d == 1) b.push_back(ra[15:8]);
        b.push_back(ra[7:0]);
        if (d == 1) b.push_back(wd[15:8]);
        b.push_back(wd[7:0]);
        np = 9 * b.size();
        e  = 1'b0;
        for (int k = 0; k < b.size(); k++) begin
            exp_byte_q[d].push_back(b[k]);
            if (mask[k]) begin
                e = 1'b1;
                if (ABORT) begin
                    np = 9 * (k + 1);
                    break;
                end
            end
        end
        exp_pulse_q[d].push_back(np);
        exp_err_q[d].push_back(e);
    endtask

    task automatic mon_step(input int d);
        logic s, a;
        logic [7:0] eb;
        s = scl_w[d];
        a = sda_line[d];
        if (mon_en[d]) begin
            if (prev_scl[d] && s && (a != prev_sda[d])) begin
                if (!a && !in_frame[d]) begin
                    in_frame[d]  = 1'b1;
                    bit_idx[d]   = 0;
                    byte_idx[d]  = 0;
                    pulses[d]    = 0;
                    seen_rise[d] = 1'b0;
                end else if (a && in_frame[d]) begin
                    in_frame[d] = 1'b0;
                    if (exp_pulse_q[d].size() == 0) begin
                        chk("stop_unexpected", d, pulses[d], -1);
                    end else begin
                        chk("scl_pulses", d, pulses[d], exp_pulse_q[d].pop_front());
                        cur_err[d] = exp_err_q[d].pop_front();
                    end
                end else begin
                    chk("sda_edge_while_scl_high", d, a, prev_sda[d]);
                end
            end else if (in_frame[d] && !prev_scl[d] && s) begin
                seen_rise[d] = 1'b1;
                bit_idx[d]++;
                if (bit_idx[d] <= 8) shreg[d] = {shreg[d][6:0], a};
                if (bit_idx[d] == 8) begin
                    bytes_seen[d]++;
                    if (exp_byte_q[d].size() == 0) begin
                        chk("byte_unexpected", d, shreg[d], -1);
                    end else begin
                        eb = exp_byte_q[d].pop_front();
                        chk("sda_byte", d, shreg[d], eb);
                    end
                end
            end else if (in_frame[d] && prev_scl[d] && !s) begin
                if (seen_rise[d]) pulses[d]++;
                if (bit_idx[d] == 8) begin
                    slave_low[d] = (byte_idx[d] < 5) ? ~nack_mask[d][byte_idx[d]] : 1'b0;
                end else if (bit_idx[d] == 9) begin
                    slave_low[d] = 1'b0;
                    bit_idx[d]   = 0;
                    byte_idx[d]++;
                end
            end
            if (done_w[d]) begin
                done_cnt[d]++;
                chk("ack_err_at_done", d, err_w[d], cur_err[d]);
                chk("busy_at_done", d, busy_w[d], 1);
                chk("stop_before_done", d, in_frame[d], 0);
                chk("bytes_left", d, exp_byte_q[d].size(), 0);
            end
        end
        prev_scl[d] = s;
        prev_sda[d] = a;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            bit_idx[d] = 0; byte_idx[d] = 0; pulses[d] = 0; done_cnt[d] = 0; bytes_seen[d] = 0;
            in_frame[d] = 1'b0; seen_rise[d] = 1'b0; prev_scl[d] = 1'b1; prev_sda[d] = 1'b1;
            mon_en[d] = 1'b1; cur_err[d] = 1'b0; shreg[d] = 8'h00; slave_low[d] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) mon_step(d);
        end
    end

    task automatic issue(input int d, input logic [6:0] dev, input logic [15:0] ra,
                         input logic [15:0] wd, input logic [4:0] mask);
        exp_push(d, dev, ra, wd, mask);
        nack_mask[d] = mask;
        @(posedge clk);
        #1;
        dev_r[d]   = dev;
        reg_r[d]   = ra;
        data_r[d]  = wd;
        start_r[d] = 1'b1;
        @(posedge clk);
        #1;
        start_r[d] = 1'b0;
    endtask

    task automatic run_txn(input int d, input logic [6:0] dev, input logic [15:0] ra,
                           input logic [15:0] wd, input logic [4:0] mask, input bit poke);
        int base;
        base = done_cnt[d];
        issue(d, dev, ra, wd, mask);
        if (poke) begin
            repeat (6 * PH_N) @(posedge clk);
            #1;
            chk("busy_mid_transfer", d, busy_w[d], 1);
            dev_r[d]   = 7'h11;
            reg_r[d]   = 16'($urandom);
            data_r[d]  = 16'($urandom);
            start_r[d] = 1'b1;
            @(posedge clk);
            #1;
            start_r[d] = 1'b0;
        end
        for (int i = 0; i < TMO && done_cnt[d] == base; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        chk("done_pulses", d, done_cnt[d] - base, 1);
        chk("busy_after_done", d, busy_w[d], 0);
    endtask

    initial begin
        int base;
        for (int d = 0; d < 2; d++) begin
            start_r[d] = 1'b0; dev_r[d] = '0; reg_r[d] = '0; data_r[d] = '0; nack_mask[d] = '0;
        end
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_scl", 0, scl_w[0], 1);
        chk("rst_sda_oen", 0, oen_w[0], 1);
        chk("rst_busy", 0, busy_w[0], 0);
        chk("rst_done", 0, done_w[0], 0);
        chk("rst_ack_err", 0, err_w[0], 0);
        chk("rst_busy", 1, busy_w[1], 0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        fork
            run_txn(0, 7'h50, 16'h00A5, 16'h003C, 5'b00000, 1'b0);
            run_txn(1, 7'h50, 16'h1234, 16'hBEEF, 5'b00000, 1'b0);
        join

        run_txn(0, 7'h50, 16'h00A5, 16'h003C, 5'b00001, 1'b0);
        chk("ack_err_sticky", 0, err_w[0], 1);

        run_txn(0, 7'h50, 16'h00A5, 16'h003C, 5'b00000, 1'b1);

        for (int i = 0; i < 6; i++) begin
            logic [4:0] m;
            for (int k = 0; k < 5; k++) m[k] = ($urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, PH_N)) @(posedge clk);
            run_txn(i % 2, 7'($urandom), 16'($urandom), 16'($urandom), m, 1'b0);
        end

        base = bytes_seen[0];
        issue(0, 7'h50, 16'h00A5, 16'h003C, 5'b00000);
        for (int i = 0; i < TMO && bytes_seen[0] == base; i++) @(posedge clk);
        chk("first_byte_before_reset", 0, bytes_seen[0] - base, 1);
        repeat (3 * PH_N) @(posedge clk);
        mon_en[0] = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_scl", 0, scl_w[0], 1);
        chk("async_rst_sda_oen", 0, oen_w[0], 1);
        chk("async_rst_busy", 0, busy_w[0], 0);
        in_frame[0]  = 1'b0;
        slave_low[0] = 1'b0;
        exp_byte_q[0].delete();
        exp_pulse_q[0].delete();
        exp_err_q[0].delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en[0] = 1'b1;
        repeat (5) @(posedge clk);
        run_txn(0, 7'h50, 16'h005A, 16'h00C3, 5'b00000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
